// File: rtl/x_stage_if.sv
// Bus between the decode-to-execute register and the execute stage:
// x_* operands/controls in, m_* execute-to-memory results and redirect out.
interface x_stage_if;
    logic [31:0] x_pc;
    logic [6:0]  x_opcode;
    logic [5:0]  x_dst_reg;
    logic [14:0] x_mem_offset;
    logic [14:0] x_brn_offset;
    logic [19:0] x_jmp_offset;
    logic [31:0] x_read_data_1;
    logic [31:0] x_read_data_2;
    logic        x_mem_read;
    logic        x_mem_write;
    logic        x_mem_byte;
    logic        x_reg_write;
    logic        x_mem_to_reg;

    logic        stall;
    logic [31:0] m_alu_out;
    logic [31:0] m_write_data;
    logic [5:0]  m_dst_reg;
    logic        m_mem_read;
    logic        m_mem_write;
    logic        m_mem_byte;
    logic        m_reg_write;
    logic        m_mem_to_reg;
    logic        branch_taken;
    logic [31:0] branch_target;

    modport master (
        output x_pc, x_opcode, x_dst_reg, x_mem_offset, x_brn_offset, x_jmp_offset,
               x_read_data_1, x_read_data_2, x_mem_read, x_mem_write, x_mem_byte,
               x_reg_write, x_mem_to_reg,
        input  stall, m_alu_out, m_write_data, m_dst_reg, m_mem_read, m_mem_write,
               m_mem_byte, m_reg_write, m_mem_to_reg, branch_taken, branch_target
    );

    modport slave (
        input  x_pc, x_opcode, x_dst_reg, x_mem_offset, x_brn_offset, x_jmp_offset,
               x_read_data_1, x_read_data_2, x_mem_read, x_mem_write, x_mem_byte,
               x_reg_write, x_mem_to_reg,
        output stall, m_alu_out, m_write_data, m_dst_reg, m_mem_read, m_mem_write,
               m_mem_byte, m_reg_write, m_mem_to_reg, branch_taken, branch_target
    );
endinterface

// File: rtl/x_stage.sv
// Execute stage with its execute-to-memory output register: ALU, address
// generation, branch/jump resolution and an iterative multiplier that holds
// the front of the pipeline while it works.
module x_stage #(
    parameter int MUL_STEP_BITS = 1
) (
    input logic   clock,
    input logic   reset,
    x_stage_if.slave bus
);
    localparam int N = 32 / MUL_STEP_BITS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [6:0] OP_ADD  = 7'h00;
    localparam logic [6:0] OP_SUB  = 7'h01;
    localparam logic [6:0] OP_MUL  = 7'h02;
    localparam logic [6:0] OP_LDB  = 7'h10;
    localparam logic [6:0] OP_LDW  = 7'h11;
    localparam logic [6:0] OP_STB  = 7'h12;
    localparam logic [6:0] OP_STW  = 7'h13;
    localparam logic [6:0] OP_MOV  = 7'h14;
    localparam logic [6:0] OP_BEQ  = 7'h30;
    localparam logic [6:0] OP_JUMP = 7'h31;

    logic [1:0]  state;
    logic [5:0]  counter;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [31:0] pp;

    logic [31:0] alu_res;
    logic        f_mem_read, f_mem_write, f_mem_byte, f_reg_write, f_mem_to_reg;
    logic        take;
    logic [31:0] target;
    logic        is_mul;

    function automatic logic signed [31:0] sext15(input logic [14:0] v);
        return {{17{v[14]}}, v};
    endfunction

    function automatic logic signed [31:0] sext20(input logic [19:0] v);
        return {{12{v[19]}}, v};
    endfunction

    assign is_mul = (bus.x_opcode == OP_MUL);

    // Hold upstream while a multiply is being launched or iterated; reset frees it.
    assign bus.stall = reset && (((state == ST_IDLE) && is_mul) || (state == ST_BUSY));

    // Single-cycle result, passed-through flags and branch resolution.
    always_comb begin
        alu_res      = '0;
        f_mem_read   = bus.x_mem_read;
        f_mem_write  = bus.x_mem_write;
        f_mem_byte   = bus.x_mem_byte;
        f_reg_write  = bus.x_reg_write;
        f_mem_to_reg = bus.x_mem_to_reg;
        take         = 1'b0;
        target       = bus.branch_target;
        case (bus.x_opcode)
            OP_ADD: alu_res = bus.x_read_data_1 + bus.x_read_data_2;
            OP_SUB: alu_res = bus.x_read_data_1 - bus.x_read_data_2;
            OP_LDB, OP_LDW, OP_STB, OP_STW:
                alu_res = bus.x_read_data_1 + $unsigned(sext15(bus.x_mem_offset));
            OP_MOV: alu_res = bus.x_read_data_1;
            OP_BEQ: begin
                take         = (bus.x_read_data_1 == bus.x_read_data_2);
                target       = bus.x_pc + $unsigned(sext15(bus.x_brn_offset));
                f_mem_read   = 1'b0;
                f_mem_write  = 1'b0;
                f_mem_byte   = 1'b0;
                f_reg_write  = 1'b0;
                f_mem_to_reg = 1'b0;
            end
            OP_JUMP: begin
                take         = 1'b1;
                target       = bus.x_pc + $unsigned(sext20(bus.x_jmp_offset));
                f_mem_read   = 1'b0;
                f_mem_write  = 1'b0;
                f_mem_byte   = 1'b0;
                f_reg_write  = 1'b0;
                f_mem_to_reg = 1'b0;
            end
            default: alu_res = '0;
        endcase
    end

    // Partial product of the low MUL_STEP_BITS multiplier bits against the shifted multiplicand.
    always_comb begin
        pp = '0;
        for (int k = 0; k < MUL_STEP_BITS; k++) begin
            if (mplier[k]) pp = pp + (mcand << k);
        end
    end

    // Multiplier sequencing: launch from IDLE, count down in BUSY, one DONE cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            counter <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_mul) begin
                        state   <= ST_BUSY;
                        counter <= 6'(N);
                    end
                end
                ST_BUSY: begin
                    counter <= counter - 6'd1;
                    if (counter == 6'd1) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Multiplier datapath: shift-and-add, operands latched at launch.
    always_ff @(posedge clock) begin
        if ((state == ST_IDLE) && is_mul) begin
            mcand  <= bus.x_read_data_1;
            mplier <= bus.x_read_data_2;
            acc    <= '0;
        end else if (state == ST_BUSY) begin
            acc    <= acc + pp;
            mcand  <= mcand << MUL_STEP_BITS;
            mplier <= mplier >> MUL_STEP_BITS;
        end
    end

    // Execute-to-memory register: results, bubbles during a multiply, redirect pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.m_alu_out     <= '0;
            bus.m_write_data  <= '0;
            bus.m_dst_reg     <= '0;
            bus.m_mem_read    <= 1'b0;
            bus.m_mem_write   <= 1'b0;
            bus.m_mem_byte    <= 1'b0;
            bus.m_reg_write   <= 1'b0;
            bus.m_mem_to_reg  <= 1'b0;
            bus.branch_taken  <= 1'b0;
            bus.branch_target <= '0;
        end else begin
            bus.branch_taken <= 1'b0;
            if (((state == ST_IDLE) && is_mul) || (state == ST_BUSY)) begin
                bus.m_alu_out    <= '0;
                bus.m_write_data <= '0;
                bus.m_dst_reg    <= '0;
                bus.m_mem_read   <= 1'b0;
                bus.m_mem_write  <= 1'b0;
                bus.m_mem_byte   <= 1'b0;
                bus.m_reg_write  <= 1'b0;
                bus.m_mem_to_reg <= 1'b0;
            end else if (state == ST_DONE) begin
                bus.m_alu_out    <= acc;
                bus.m_write_data <= bus.x_read_data_2;
                bus.m_dst_reg    <= bus.x_dst_reg;
                bus.m_mem_read   <= bus.x_mem_read;
                bus.m_mem_write  <= bus.x_mem_write;
                bus.m_mem_byte   <= bus.x_mem_byte;
                bus.m_reg_write  <= bus.x_reg_write;
                bus.m_mem_to_reg <= bus.x_mem_to_reg;
            end else begin
                bus.m_alu_out    <= alu_res;
                bus.m_write_data <= bus.x_read_data_2;
                bus.m_dst_reg    <= bus.x_dst_reg;
                bus.m_mem_read   <= f_mem_read;
                bus.m_mem_write  <= f_mem_write;
                bus.m_mem_byte   <= f_mem_byte;
                bus.m_reg_write  <= f_reg_write;
                bus.m_mem_to_reg <= f_mem_to_reg;
                bus.branch_taken <= take;
                if (take) bus.branch_target <= target;
            end
        end
    end
endmodule

// File: tb/tb_x_stage.sv
// Bench for x_stage: two instances (1-bit and 4-bit multiplier steps) driven
// with directed instructions and checked every cycle against a reference model.
module tb_x_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [5:0]  dst;
        logic [14:0] mo;
        logic [14:0] bo;
        logic [19:0] jo;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        mr, mw, mb, rw, m2r;
    } instr_t;

    typedef struct packed {
        logic        stall;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [5:0]  dst;
        logic        mr, mw, mb, rw, m2r, bt;
        logic [31:0] tgt;
    } out_t;

    logic   clock = 1'b0;
    logic   reset = 1'b0;
    instr_t drv0, drv1;
    out_t   act0, act1;
    out_t   exp_o [2];
    bit     run = 1'b0;
    int     n_chk = 0;
    int     n_fail = 0;

    x_stage_if bus0 ();
    x_stage_if bus1 ();

    x_stage #(.MUL_STEP_BITS(1)) dut0 (.clock(clock), .reset(reset), .bus(bus0.slave));
    x_stage #(.MUL_STEP_BITS(4)) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

    assign {bus0.x_pc, bus0.x_opcode, bus0.x_dst_reg, bus0.x_mem_offset, bus0.x_brn_offset,
            bus0.x_jmp_offset, bus0.x_read_data_1, bus0.x_read_data_2, bus0.x_mem_read,
            bus0.x_mem_write, bus0.x_mem_byte, bus0.x_reg_write, bus0.x_mem_to_reg} = drv0;
    assign {bus1.x_pc, bus1.x_opcode, bus1.x_dst_reg, bus1.x_mem_offset, bus1.x_brn_offset,
            bus1.x_jmp_offset, bus1.x_read_data_1, bus1.x_read_data_2, bus1.x_mem_read,
            bus1.x_mem_write, bus1.x_mem_byte, bus1.x_reg_write, bus1.x_mem_to_reg} = drv1;
    assign act0 = {bus0.stall, bus0.m_alu_out, bus0.m_write_data, bus0.m_dst_reg,
                   bus0.m_mem_read, bus0.m_mem_write, bus0.m_mem_byte, bus0.m_reg_write,
                   bus0.m_mem_to_reg, bus0.branch_taken, bus0.branch_target};
    assign act1 = {bus1.stall, bus1.m_alu_out, bus1.m_write_data, bus1.m_dst_reg,
                   bus1.m_mem_read, bus1.m_mem_write, bus1.m_mem_byte, bus1.m_reg_write,
                   bus1.m_mem_to_reg, bus1.branch_taken, bus1.branch_target};

    always #5 clock = ~clock;

    function automatic instr_t mk(input logic [6:0] op, input logic [31:0] pc,
                                  input logic [31:0] rd1, input logic [31:0] rd2,
                                  input logic [5:0] dst, input logic [14:0] mo,
                                  input logic [14:0] bo, input logic [19:0] jo,
                                  input logic [4:0] fl);
        instr_t i;
        i.pc = pc; i.op = op; i.dst = dst; i.mo = mo; i.bo = bo; i.jo = jo;
        i.rd1 = rd1; i.rd2 = rd2;
        {i.mr, i.mw, i.mb, i.rw, i.m2r} = fl;
        return i;
    endfunction

    function automatic instr_t nop_i();
        return mk(7'h3F, 32'h0, 32'h0, 32'h0, 6'h0, 15'h0, 15'h0, 20'h0, 5'b0);
    endfunction

    // Architectural effect of one instruction leaving X, in plain arithmetic.
    function automatic out_t model(input instr_t i, input logic [31:0] prev_tgt);
        out_t o;
        logic [31:0] a, b;
        o = '0;
        a = i.rd1; b = i.rd2;
        o.tgt = prev_tgt;
        o.wd = b;
        o.dst = i.dst;
        {o.mr, o.mw, o.mb, o.rw, o.m2r} = {i.mr, i.mw, i.mb, i.rw, i.m2r};
        case (i.op)
            7'h00: o.alu = a + b;
            7'h01: o.alu = a - b;
            7'h02: o.alu = a * b;
            7'h10, 7'h11, 7'h12, 7'h13: o.alu = a + {{17{i.mo[14]}}, i.mo};
            7'h14: o.alu = a;
            7'h30: begin
                {o.mr, o.mw, o.mb, o.rw, o.m2r} = 5'b0;
                if (a == b) begin
                    o.bt = 1'b1;
                    o.tgt = i.pc + {{17{i.bo[14]}}, i.bo};
                end
            end
            7'h31: begin
                {o.mr, o.mw, o.mb, o.rw, o.m2r} = 5'b0;
                o.bt = 1'b1;
                o.tgt = i.pc + {{12{i.jo[19]}}, i.jo};
            end
            default: o.alu = 32'h0;
        endcase
        return o;
    endfunction

    function automatic out_t bubble(input logic [31:0] prev_tgt);
        out_t o;
        o = '0;
        o.tgt = prev_tgt;
        return o;
    endfunction

    task automatic chk(input int u, input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL u%0d %s at %0t: got %h expected %h", u, nm, $time, a, e);
        end
    endtask

    task automatic cmp_unit(input int u, input out_t a, input out_t e);
        chk(u, "stall", 32'(a.stall), 32'(e.stall));
        chk(u, "m_alu_out", a.alu, e.alu);
        chk(u, "m_write_data", a.wd, e.wd);
        chk(u, "m_dst_reg", 32'(a.dst), 32'(e.dst));
        chk(u, "m_flags", 32'({a.mr, a.mw, a.mb, a.rw, a.m2r}), 32'({e.mr, e.mw, e.mb, e.rw, e.m2r}));
        chk(u, "branch_taken", 32'(a.bt), 32'(e.bt));
        chk(u, "branch_target", a.tgt, e.tgt);
    endtask

    // Per-cycle comparison of both instances against the model, mid-cycle.
    always @(negedge clock) begin
        if (run) begin
            cmp_unit(0, act0, exp_o[0]);
            cmp_unit(1, act1, exp_o[1]);
        end
    end

    task automatic set_drv(input int u, input instr_t i);
        if (u == 0) drv0 = i; else drv1 = i;
    endtask

    function automatic out_t act_of(input int u);
        return (u == 0) ? act0 : act1;
    endfunction

    // Present one instruction on unit u, hold it for as long as the model says
    // it must stall, and update the expected outputs after every edge.
    task automatic issue(input int u, input instr_t i, input logic [31:0] lit, input bit use_lit);
        int o;
        int n;
        o = 1 - u;
        set_drv(u, i);
        set_drv(o, nop_i());
        if (i.op == 7'h02) begin
            n = 32 / ((u == 0) ? 1 : 4);
            exp_o[u].stall = 1'b1;
            for (int k = 1; k <= n + 1; k++) begin
                @(posedge clock); #1;
                exp_o[u] = bubble(exp_o[u].tgt);
                exp_o[u].stall = (k <= n);
                exp_o[o] = model(nop_i(), exp_o[o].tgt);
            end
        end
        @(posedge clock); #1;
        exp_o[u] = model(i, exp_o[u].tgt);
        exp_o[o] = model(nop_i(), exp_o[o].tgt);
        if (use_lit) chk(u, "lit_alu", act_of(u).alu, lit);
        set_drv(u, nop_i());
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        instr_t r;
        drv0 = nop_i();
        drv1 = nop_i();
        exp_o[0] = '0;
        exp_o[1] = '0;
        reset = 1'b0;
        run = 1'b1;

        // Reset held with random inputs, MUL opcode included.
        for (int k = 0; k < 4; k++) begin
            r = mk((k == 1) ? 7'h02 : 7'($urandom_range(0, 127)), $urandom, $urandom, $urandom,
                   6'($urandom), 15'($urandom), 15'($urandom), 20'($urandom), 5'($urandom));
            drv0 = r;
            drv1 = r;
            @(posedge clock); #1;
        end
        chk(0, "rst_stall", 32'(act0.stall), 32'h0);
        chk(0, "rst_alu", act0.alu, 32'h0);
        drv0 = nop_i();
        drv1 = nop_i();
        reset = 1'b1;

        // Single-cycle operations.
        issue(0, mk(7'h00, 32'h0, 32'd5, 32'd7, 6'd3, 15'h0, 15'h0, 20'h0, 5'b00010), 32'd12, 1);
        chk(0, "add_reg_write", 32'(act0.rw), 32'h1);
        issue(0, mk(7'h01, 32'h0, 32'd0, 32'd1, 6'd4, 15'h0, 15'h0, 20'h0, 5'b00010), 32'hFFFFFFFF, 1);
        issue(0, mk(7'h11, 32'h0, 32'h100, 32'h55, 6'd5, 15'h7FFC, 15'h0, 20'h0, 5'b10011), 32'hFC, 1);
        chk(0, "ldw_flags", 32'({act0.mr, act0.m2r}), 32'h3);
        issue(0, mk(7'h14, 32'h0, 32'hDEADBEEF, 32'h1, 6'd6, 15'h0, 15'h0, 20'h0, 5'b00010), 32'hDEADBEEF, 1);
        issue(0, mk(7'h12, 32'h0, 32'h200, 32'hA5, 6'd0, 15'h0010, 15'h0, 20'h0, 5'b01100), 32'h210, 1);
        issue(0, mk(7'h7F, 32'h0, 32'd9, 32'd2, 6'd7, 15'h0, 15'h0, 20'h0, 5'b00011), 32'h0, 1);

        // Multiply with 1-bit steps.
        issue(0, mk(7'h02, 32'h0, 32'h12345678, 32'h10, 6'd8, 15'h0, 15'h0, 20'h0, 5'b00010), 32'h23456780, 1);
        issue(0, mk(7'h02, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd9, 15'h0, 15'h0, 20'h0, 5'b00010), 32'h1, 1);

        // Branches and jump.
        issue(0, mk(7'h30, 32'h40, 32'd3, 32'd3, 6'd1, 15'h0, 15'h7FF8, 20'h0, 5'b00010), 32'h0, 0);
        chk(0, "beq_taken", 32'(act0.bt), 32'h1);
        chk(0, "beq_target", act0.tgt, 32'h38);
        chk(0, "beq_reg_write", 32'(act0.rw), 32'h0);
        issue(0, mk(7'h30, 32'h80, 32'd3, 32'd4, 6'd1, 15'h0, 15'h0010, 20'h0, 5'b00010), 32'h0, 0);
        chk(0, "beq_not_taken", 32'(act0.bt), 32'h0);
        chk(0, "beq_target_hold", act0.tgt, 32'h38);
        issue(0, mk(7'h31, 32'h40, 32'd0, 32'd0, 6'd2, 15'h0, 15'h0, 20'h00100, 5'b11111), 32'h0, 0);
        chk(0, "jump_target", act0.tgt, 32'h140);
        chk(0, "jump_flags", 32'({act0.mr, act0.mw, act0.mb, act0.rw}), 32'h0);
        issue(0, nop_i(), 32'h0, 1);
        chk(0, "taken_pulse_end", 32'(act0.bt), 32'h0);

        // Reset in the 10th busy cycle of a 1-bit-step multiply.
        drv0 = mk(7'h02, 32'h0, 32'd7, 32'd9, 6'd10, 15'h0, 15'h0, 20'h0, 5'b00010);
        drv1 = nop_i();
        exp_o[0].stall = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1;
            exp_o[0] = bubble(exp_o[0].tgt);
            exp_o[0].stall = 1'b1;
            exp_o[1] = model(nop_i(), exp_o[1].tgt);
        end
        #1 reset = 1'b0;
        exp_o[0] = '0;
        exp_o[1] = '0;
        #1;
        chk(0, "midrst_stall", 32'(act0.stall), 32'h0);
        chk(0, "midrst_target", act0.tgt, 32'h0);
        drv0 = nop_i();
        @(posedge clock); #1;
        reset = 1'b1;
        issue(0, mk(7'h02, 32'h0, 32'd3, 32'd4, 6'd11, 15'h0, 15'h0, 20'h0, 5'b00010), 32'd12, 1);

        // Back-to-back multiplies with 4-bit steps.
        issue(1, mk(7'h02, 32'h0, 32'd2, 32'd3, 6'd12, 15'h0, 15'h0, 20'h0, 5'b00010), 32'd6, 1);
        issue(1, mk(7'h02, 32'h0, 32'd4, 32'd5, 6'd13, 15'h0, 15'h0, 20'h0, 5'b00010), 32'd20, 1);
        issue(1, mk(7'h02, 32'h0, 32'h12345678, 32'h9ABCDEF0, 6'd14, 15'h0, 15'h0, 20'h0, 5'b00010), 32'h0, 0);
        issue(1, mk(7'h00, 32'h0, 32'hFFFFFFFF, 32'd2, 6'd15, 15'h0, 15'h0, 20'h0, 5'b00010), 32'd1, 1);
        issue(1, nop_i(), 32'h0, 1);

        @(posedge clock); #1;
        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
